inst_prefetch_buffer: RTL
=========================

Name: inst_prefetch_buffer

Overview:
- Sits between the CPU fetch stage and icache_top.
- Walks a sequential PC and issues one instruction request at a time to the I-cache.
- Queues the returned {pc, instruction} pairs in a small FIFO that the decode stage drains.
- A redirect (branch, jump or exception) flushes the queue and any in-flight response, then restarts fetch at the new PC.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 4, FIFO entries; power of two, >= 2
PTR_W, 2, log2(DEPTH)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  32  new fetch PC; bits [1:0] ignored and forced to 0
inst_valid  out  1  FIFO head is valid
inst_data  out  32  instruction at FIFO head
inst_pc  out  32  PC of FIFO head
inst_ready  in  1  decode accepts the head entry
to_icache_inst_req_valid  out  1  request valid to icache_top
to_icache_inst_req_addr  out  32  request address, 4-byte aligned
from_icache_inst_req_ready  in  1  I-cache accepts request
from_icache_rsp_valid  in  1  I-cache instruction valid
from_icache_rsp_data  in  32  I-cache instruction
to_icache_rsp_ready  out  1  buffer accepts I-cache response

Behaviour:
- Reset, all synchronous on rst=1:
  - state=IDLE, fetch_pc=RESET_PC, FIFO empty (rd_ptr=wr_ptr=0, count=0), drop=0.
  - All outputs read 0: inst_valid, to_icache_inst_req_valid, to_icache_rsp_ready, addr.
- Handshakes: a transfer occurs when valid && ready on the same rising edge.
- States:
  - IDLE: next cycle goes to REQ unconditionally.
  - REQ:
    - to_icache_inst_req_valid = (count < DEPTH) && !redirect_valid.
    - addr = fetch_pc.
    - On request handshake: req_pc <= fetch_pc; go to WAIT_RSP.
  - WAIT_RSP:
    - to_icache_inst_req_valid = 0.
    - to_icache_inst_req_addr = req_pc, held stable until the response handshake, because the I-cache decodes the address combinationally during lookup and refill.
    - to_icache_rsp_ready = 1.
    - On response handshake with drop=0 and no redirect: push {req_pc, data}; fetch_pc <= req_pc + 4; go to REQ.
    - On response handshake with drop=1 or redirect_valid: discard the data; clear drop; go to REQ.
- Outstanding requests: at most one. A request is issued only when count < DEPTH, so every accepted response has a free slot.
- Push and pop:
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - PC wraps 32'hFFFF_FFFC + 4 = 32'h0.
- inst_valid = (count != 0) && !redirect_valid. inst_pc and inst_data come from the head entry. No pop can occur in a redirect cycle.
- Redirect (highest priority, any state except during rst):
  - FIFO cleared next cycle.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - In WAIT_RSP without a response in that cycle: drop <= 1, stay in WAIT_RSP.
  - In WAIT_RSP with a response in the same cycle: discard it, go to REQ.
  - In REQ: no request is issued that cycle; stay in REQ.
  - A second redirect while drop=1 only updates fetch_pc.
- Latency: with an always-ready decode stage and an I-cache hit (1 cycle after accept), the first inst_valid appears 3 cycles after reset deassertion. Steady state is one instruction per 2 cycles.
- Reset mid-operation: state and FIFO return to reset values. A later I-cache response is accepted only in WAIT_RSP; the I-cache is reset by the same rst, so no stale response survives.
- Reset of fetch_pc has priority over a simultaneous redirect.

Decomposition:
- Shared package holds the state encodings IDLE, REQ and WAIT_RSP (one-hot, 3 bits), the RESET_PC default and the instruction width constant 32.
- One natural sub-module: fetch_fifo, a synchronous FIFO parameterised by DEPTH and width 64. It provides push, pop, flush, count, head data and full/empty.
- The FSM, PC register and drop flag stay in inst_prefetch_buffer.

Test Plan:
- Reset release, RESET_PC=0, I-cache replies 1 cycle after each accept with data=addr^32'hA5A5_0000, inst_ready=1 -> the decode stage sees pc 0,4,8,C in order, each with matching data; req_addr stays stable through every WAIT_RSP.
- inst_ready=0 for 20 cycles -> exactly 4 entries are queued; to_icache_inst_req_valid is 0 once count=4; raising inst_ready drains pc 0..C, then fetch resumes at 0x10.
- Redirect to 0x1000 while in WAIT_RSP for 0x8 with a 5-cycle miss -> the 0x8 response is dropped; the next request address is 0x1000; the first inst_pc is 0x1000; no 0x8 entry is visible.
- Redirect to 0x2002 in the same cycle as a response handshake -> that response is discarded; the next request goes to 0x2000; the FIFO is empty the following cycle.
- redirect_pc=32'hFFFF_FFFC, then two fetches -> inst_pc is FFFF_FFFC then 0000_0000.
- rst asserted for 1 cycle while the FIFO holds 3 entries and a request is outstanding -> inst_valid=0 next cycle; the first request after reset goes to RESET_PC.

Source files
------------

// File: rtl/inst_prefetch_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_prefetch_buffer_pkg
// Purpose  : Shared types and constants for the instruction prefetch buffer:
//            one-hot fetch FSM encoding, reset PC default, instruction width
//            and a word-alignment helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package inst_prefetch_buffer_pkg;

    localparam int          INST_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One-hot so each state decodes from a single flop.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'b001,
        ST_REQ      = 3'b010,
        ST_WAIT_RSP = 3'b100
    } pf_state_e;

    // Instructions are 4-byte aligned; low address bits are discarded.
    function automatic logic [31:0] align4(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_prefetch_buffer_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : inst_prefetch_buffer_fetch_fifo
// Purpose  : Synchronous FIFO holding {pc, instruction} pairs between the
//            I-cache response path and the decode stage. Flush empties the
//            queue in one cycle and takes priority over push and pop.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            push_i/push_data_i - write an entry (ignored when full)
//            pop_i             - remove the head entry (ignored when empty)
//            flush_i           - discard all entries
//            count_o           - number of valid entries (0..DEPTH)
//            head_o            - data at the head of the queue
//            full_o/empty_o    - occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module inst_prefetch_buffer_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [PTR_W:0]   count_o,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W:0]   count_q;

    logic do_push;
    logic do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o  && !flush_i;
    assign do_pop  = pop_i  && !empty_o && !flush_i;

    // Pointers are PTR_W bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    // Storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/inst_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : inst_prefetch_buffer
// Purpose  : Walks a sequential PC, issues one I-cache request at a time and
//            queues returned {pc, instruction} pairs for the decode stage.
//            A redirect flushes the queue, drops any in-flight response and
//            restarts fetch at the new PC.
// Ports    : clk, rst                     - clock, sync active-high reset
//            redirect_valid/redirect_pc   - flush and restart fetch
//            inst_valid/inst_data/inst_pc - FIFO head to decode
//            inst_ready                   - decode accepts the head
//            to_icache_inst_req_valid/addr, from_icache_inst_req_ready
//                                         - request channel to I-cache
//            from_icache_rsp_valid/data, to_icache_rsp_ready
//                                         - response channel from I-cache
// Revision : 1.0 - initial release
// ============================================================================
module inst_prefetch_buffer
    import inst_prefetch_buffer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 4,
    parameter int          PTR_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_data,
    output logic [31:0]       inst_pc,
    input  logic              inst_ready,
    output logic              to_icache_inst_req_valid,
    output logic [31:0]       to_icache_inst_req_addr,
    input  logic              from_icache_inst_req_ready,
    input  logic              from_icache_rsp_valid,
    input  logic [INST_W-1:0] from_icache_rsp_data,
    output logic              to_icache_rsp_ready
);

    pf_state_e   state_q;
    logic [31:0] fetch_pc_q;
    logic [31:0] req_pc_q;
    logic        drop_q;

    logic [PTR_W:0]       fifo_count;
    logic [32+INST_W-1:0] fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;

    logic req_hs;
    logic rsp_hs;
    logic push;
    logic pop;

    // Only one request is ever outstanding, so a request is issued only when
    // a slot is guaranteed for its response.
    assign to_icache_inst_req_valid = (state_q == ST_REQ)
                                   && (fifo_count < (PTR_W+1)'(DEPTH))
                                   && !redirect_valid;
    assign to_icache_rsp_ready      = (state_q == ST_WAIT_RSP);

    // The I-cache decodes the address combinationally during lookup and
    // refill, so it is held at req_pc until the response handshake.
    always_comb begin
        to_icache_inst_req_addr = 32'h0;
        case (state_q)
            ST_REQ:      to_icache_inst_req_addr = fetch_pc_q;
            ST_WAIT_RSP: to_icache_inst_req_addr = req_pc_q;
            default:     to_icache_inst_req_addr = 32'h0;
        endcase
    end

    assign req_hs = to_icache_inst_req_valid && from_icache_inst_req_ready;
    assign rsp_hs = from_icache_rsp_valid && to_icache_rsp_ready;

    // The full term never fires by construction; it keeps an overflow
    // impossible even if the I-cache misbehaves.
    assign push = rsp_hs && !drop_q && !redirect_valid && !fifo_full;

    assign inst_valid = !fifo_empty && !redirect_valid;
    assign pop        = inst_valid && inst_ready;
    assign inst_pc    = fifo_head[32+INST_W-1:INST_W];
    assign inst_data  = fifo_head[INST_W-1:0];

    inst_prefetch_buffer_fetch_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .WIDTH (32 + INST_W)
    ) u_fetch_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i ({req_pc_q, from_icache_rsp_data}),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .count_o     (fifo_count),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= 32'h0;
            drop_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_REQ;
                end
                ST_REQ: begin
                    // No request can handshake during a redirect cycle.
                    if (req_hs) begin
                        req_pc_q <= fetch_pc_q;
                        state_q  <= ST_WAIT_RSP;
                    end
                end
                ST_WAIT_RSP: begin
                    if (rsp_hs) begin
                        drop_q  <= 1'b0;
                        state_q <= ST_REQ;
                        if (!drop_q && !redirect_valid) begin
                            fetch_pc_q <= req_pc_q + 32'd4;
                        end
                    end else if (redirect_valid) begin
                        // The response for the old path is still coming;
                        // swallow it when it arrives.
                        drop_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            // Redirect wins over the sequential increment above.
            if (redirect_valid) begin
                fetch_pc_q <= align4(redirect_pc);
            end
        end
    end

endmodule
`default_nettype wire
